// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the unified-RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned DEF_STARVE_LIM = 8;

  // Which requester owns the RAM access (and therefore the next read response).
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_DM   = 2'd2,
    SRC_EX   = 2'd3
  } src_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM side signals of the arbiter.
// slave: the arbiter; master: the core, the loader and the RAM around it.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::DEF_ADDR_W
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  logic              dm_req;
  logic              dm_we;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;

  logic              ex_req;
  logic              ex_we;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_wdata;
  logic              ex_gnt;
  logic              ex_rvalid;

  logic [31:0]       rdata;
  logic              misalign;
  logic              stall;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  ex_req, ex_we, ex_addr, ex_wdata,
    input  ram_rdata,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, ex_gnt, ex_rvalid,
    output rdata, misalign, stall,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output ex_req, ex_we, ex_addr, ex_wdata,
    output ram_rdata,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, ex_gnt, ex_rvalid,
    input  rdata, misalign, stall,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating refusal counter; sat tells the arbiter EX has waited long enough.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIM = mem_arb_pkg::DEF_STARVE_LIM
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  logic [7:0] cnt;

  assign sat = (cnt == LIM);

  // Count refused cycles, hold at the limit, drop to zero on clear.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported synchronous RAM between instruction fetch, data
// memory and an external loader port; stalls the core on refused requests.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned STARVE_LIM = DEF_STARVE_LIM
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  src_e              sel;
  src_e              resp_src;
  logic              ex_sat;
  logic              rr_contend;
  logic              rr_ex_next;
  logic              misalign_q;
  logic              access;
  logic              aligned;
  logic [ADDR_W+1:0] acc_addr;
  logic              acc_we;
  logic [31:0]       acc_wdata;

  arb_starve_ctr #(
    .STARVE_LIM(STARVE_LIM)
  ) u_starve (
    .clk  (clk),
    .reset(reset),
    .inc  (bus.ex_req & ~bus.ex_gnt),
    .clr  (bus.ex_gnt | ~bus.ex_req),
    .sat  (ex_sat)
  );

  // IF and EX compete with DM idle and EX not starved: the pointer decides.
  assign rr_contend = bus.if_req & bus.ex_req & ~bus.dm_req & ~ex_sat;

  // Fixed-priority grant selection with round-robin between IF and EX.
  always_comb begin
    sel = SRC_NONE;
    if (bus.ex_req && ex_sat) begin
      sel = SRC_EX;
    end else if (bus.dm_req) begin
      sel = SRC_DM;
    end else if (rr_contend) begin
      sel = rr_ex_next ? SRC_EX : SRC_IF;
    end else if (bus.if_req) begin
      sel = SRC_IF;
    end else if (bus.ex_req) begin
      sel = SRC_EX;
    end
  end

  // Route the granted requester's address and write data towards the RAM.
  always_comb begin
    acc_addr  = '0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    unique case (sel)
      SRC_IF: begin
        acc_addr = bus.if_addr[ADDR_W+1:0];
      end
      SRC_DM: begin
        acc_addr  = bus.dm_addr[ADDR_W+1:0];
        acc_we    = bus.dm_we;
        acc_wdata = bus.dm_wdata;
      end
      SRC_EX: begin
        acc_addr  = bus.ex_addr[ADDR_W+1:0];
        acc_we    = bus.ex_we;
        acc_wdata = bus.ex_wdata;
      end
      default: begin
      end
    endcase
  end

  assign access  = (sel != SRC_NONE) & ~reset;
  assign aligned = (acc_addr[1:0] == 2'b00);

  assign bus.if_gnt    = (sel == SRC_IF);
  assign bus.dm_gnt    = (sel == SRC_DM);
  assign bus.ex_gnt    = (sel == SRC_EX);
  assign bus.stall     = (bus.if_req & ~bus.if_gnt) | (bus.dm_req & ~bus.dm_gnt);

  assign bus.ram_en    = access;
  assign bus.ram_we    = access & acc_we & aligned;
  assign bus.ram_addr  = acc_addr[ADDR_W+1:2];
  assign bus.ram_wdata = acc_wdata;

  // Response is gated by reset so a read granted just before reset is dropped.
  assign bus.if_rvalid = (resp_src == SRC_IF) & ~reset;
  assign bus.dm_rvalid = (resp_src == SRC_DM) & ~reset;
  assign bus.ex_rvalid = (resp_src == SRC_EX) & ~reset;
  assign bus.rdata     = bus.ram_rdata;
  assign bus.misalign  = misalign_q;

  // Track read ownership, the IF/EX pointer and the misalignment pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ex_next <= 1'b0;
      resp_src   <= SRC_NONE;
      misalign_q <= 1'b0;
    end else begin
      if (rr_contend) begin
        rr_ex_next <= ~rr_ex_next;
      end
      resp_src   <= (access && !acc_we) ? sel : SRC_NONE;
      misalign_q <= access && !aligned;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level reference model and a shadow memory.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned STARVE_LIM = 8;
  localparam int unsigned WORDS      = 1 << ADDR_W;

  localparam int S_NONE = 0;
  localparam int S_IF   = 1;
  localparam int S_DM   = 2;
  localparam int S_EX   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) b ();

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (b)
  );

  // RAM environment: single port, one cycle read latency.
  logic [31:0] ram_mem [WORDS] = '{default: '0};
  logic [31:0] ram_q = '0;
  assign b.ram_rdata = ram_q;
  always @(posedge clk) begin
    if (b.ram_en) begin
      if (b.ram_we) ram_mem[b.ram_addr] <= b.ram_wdata;
      else          ram_q <= ram_mem[b.ram_addr];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [WORDS];
  int          m_starve;
  bit          m_rr_ex;
  int          m_pend;
  logic [31:0] m_pend_data;
  bit          m_mis;

  int checks = 0;
  int fails  = 0;

  function automatic int word_of(logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  function automatic int predict();
    if (b.ex_req && m_starve >= int'(STARVE_LIM)) return S_EX;
    if (b.dm_req) return S_DM;
    if (b.if_req && b.ex_req) return m_rr_ex ? S_EX : S_IF;
    if (b.if_req) return S_IF;
    if (b.ex_req) return S_EX;
    return S_NONE;
  endfunction

  function automatic logic [31:0] req_addr(int w);
    if (w == S_IF) return b.if_addr;
    if (w == S_DM) return b.dm_addr;
    if (w == S_EX) return b.ex_addr;
    return '0;
  endfunction

  function automatic bit req_we(int w);
    return (w == S_DM && b.dm_we) || (w == S_EX && b.ex_we);
  endfunction

  function automatic logic [31:0] req_wdata(int w);
    return (w == S_EX) ? b.ex_wdata : b.dm_wdata;
  endfunction

  // Apply one clock of the arbitration rules to the model state.
  task automatic model_commit();
    int w;
    logic [31:0] a;
    w = predict();
    if (reset) begin
      m_starve = 0; m_rr_ex = 0; m_pend = S_NONE; m_mis = 0;
      return;
    end
    a      = req_addr(w);
    m_mis  = (w != S_NONE) && (a % 4 != 0);
    m_pend = S_NONE;
    if (w != S_NONE) begin
      if (!req_we(w)) begin
        m_pend      = w;
        m_pend_data = ref_mem[word_of(a)];
      end else if (a % 4 == 0) begin
        ref_mem[word_of(a)] = req_wdata(w);
      end
    end
    if (b.if_req && b.ex_req && !b.dm_req && m_starve < int'(STARVE_LIM))
      m_rr_ex = (w == S_IF);
    if (b.ex_req && w != S_EX) m_starve = (m_starve < int'(STARVE_LIM)) ? m_starve + 1 : int'(STARVE_LIM);
    else                       m_starve = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.if_req = 0; b.if_addr = '0;
    b.dm_req = 0; b.dm_we = 0; b.dm_addr = '0; b.dm_wdata = '0;
    b.ex_req = 0; b.ex_we = 0; b.ex_addr = '0; b.ex_wdata = '0;
  endtask

  task automatic ex_write(logic [31:0] a, logic [31:0] d);
    idle();
    b.ex_req = 1; b.ex_we = 1; b.ex_addr = a; b.ex_wdata = d;
    advance();
    idle();
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1;
    advance();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    b.dm_req = 1; b.dm_we = 1; b.dm_addr = 32'h40; b.dm_wdata = 32'hBAD0BAD0;
    settle();
    checks++; if (b.ram_en !== 1'b0) $display("FAIL reset_ram_en: got %0b expected 0", b.ram_en);
    if (b.ram_en !== 1'b0) fails++;
    advance(); advance();
    reset = 0; idle();
    settle();
    checks++;
    if ({b.if_rvalid, b.dm_rvalid, b.ex_rvalid, b.misalign} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000", {b.if_rvalid, b.dm_rvalid, b.ex_rvalid, b.misalign});
    end
    advance();
    b.dm_req = 1; b.dm_addr = 32'h40;
    advance(); idle();
    settle();
    checks++;
    if (b.dm_rvalid !== 1'b1 || b.rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_write_blocked: got rvalid=%0b rdata=%0h expected 1/0", b.dm_rvalid, b.rdata);
    end
    advance();
  endtask

  task automatic test_single_if();
    ex_write(32'h10, 32'hDEADBEEF);
    b.if_req = 1; b.if_addr = 32'h10;
    settle();
    checks++;
    if (b.if_gnt !== 1'b1 || b.ram_addr !== 12'd4 || b.stall !== 1'b0) begin
      fails++;
      $display("FAIL single_if_grant: got gnt=%0b addr=%0h stall=%0b expected 1/4/0", b.if_gnt, b.ram_addr, b.stall);
    end
    advance(); idle();
    settle();
    checks++;
    if (b.if_rvalid !== 1'b1 || b.rdata !== 32'hDEADBEEF || b.stall !== 1'b0) begin
      fails++;
      $display("FAIL single_if_data: got rvalid=%0b rdata=%0h stall=%0b expected 1/deadbeef/0", b.if_rvalid, b.rdata, b.stall);
    end
    advance();
  endtask

  task automatic test_dm_if_contention();
    int dm_rv = 0;
    int if_rv = 0;
    b.if_req = 1; b.if_addr = 32'h10;
    b.dm_req = 1; b.dm_we = 0;
    for (int k = 0; k < 3; k++) begin
      b.dm_addr = 32'h100 + 32'(4 * k);
      settle();
      dm_rv += int'(b.dm_rvalid); if_rv += int'(b.if_rvalid);
      checks++;
      if (b.dm_gnt !== 1'b1 || b.if_gnt !== 1'b0 || b.stall !== 1'b1) begin
        fails++;
        $display("FAIL contention_dm_cycle%0d: got dm=%0b if=%0b stall=%0b expected 1/0/1", k, b.dm_gnt, b.if_gnt, b.stall);
      end
      advance();
    end
    b.dm_req = 0;
    settle();
    dm_rv += int'(b.dm_rvalid); if_rv += int'(b.if_rvalid);
    checks++;
    if (b.if_gnt !== 1'b1 || b.stall !== 1'b0) begin
      fails++;
      $display("FAIL contention_if_cycle4: got if=%0b stall=%0b expected 1/0", b.if_gnt, b.stall);
    end
    advance(); idle();
    settle();
    dm_rv += int'(b.dm_rvalid); if_rv += int'(b.if_rvalid);
    checks++;
    if (dm_rv != 3 || if_rv != 1 || b.rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL contention_rvalid_count: got dm=%0d if=%0d rdata=%0h expected 3/1/deadbeef", dm_rv, if_rv, b.rdata);
    end
    advance();
  endtask

  task automatic test_round_robin();
    pulse_reset();
    b.if_req = 1; b.if_addr = 32'h8;
    b.ex_req = 1; b.ex_we = 0; b.ex_addr = 32'hC;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++;
      if ({b.if_gnt, b.ex_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL round_robin_%0d: got if/ex=%b expected %b", k, {b.if_gnt, b.ex_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      advance();
    end
    idle();
    advance();
  endtask

  task automatic test_starvation();
    pulse_reset();
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h30;
    b.ex_req = 1; b.ex_we = 0; b.ex_addr = 32'h34;
    for (int cyc = 1; cyc <= int'(STARVE_LIM) + 3; cyc++) begin
      settle();
      checks++;
      if (b.ex_gnt !== (cyc == int'(STARVE_LIM) + 1) || b.dm_gnt !== (cyc != int'(STARVE_LIM) + 1)) begin
        fails++;
        $display("FAIL starvation_cycle%0d: got ex=%0b dm=%0b expected ex=%0b", cyc, b.ex_gnt, b.dm_gnt, cyc == int'(STARVE_LIM) + 1);
      end
      advance();
    end
    idle();
    advance();
  endtask

  task automatic test_misaligned_write();
    ex_write(32'h20, 32'hCAFEF00D);
    b.dm_req = 1; b.dm_we = 1; b.dm_addr = 32'h22; b.dm_wdata = 32'h1234;
    settle();
    checks++;
    if (b.dm_gnt !== 1'b1 || b.ram_en !== 1'b1 || b.ram_we !== 1'b0) begin
      fails++;
      $display("FAIL misalign_write_strobe: got gnt=%0b en=%0b we=%0b expected 1/1/0", b.dm_gnt, b.ram_en, b.ram_we);
    end
    advance(); idle();
    settle();
    checks++;
    if (b.misalign !== 1'b1 || b.dm_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL misalign_pulse: got misalign=%0b rvalid=%0b expected 1/0", b.misalign, b.dm_rvalid);
    end
    b.dm_req = 1; b.dm_addr = 32'h20;
    advance(); idle();
    settle();
    checks++;
    if (b.dm_rvalid !== 1'b1 || b.rdata !== 32'hCAFEF00D || b.misalign !== 1'b0) begin
      fails++;
      $display("FAIL misalign_readback: got rvalid=%0b rdata=%0h mis=%0b expected 1/cafef00d/0", b.dm_rvalid, b.rdata, b.misalign);
    end
    advance();
  endtask

  task automatic test_reset_mid_read();
    b.dm_req = 1; b.dm_we = 0; b.dm_addr = 32'h20;
    settle();
    checks++;
    if (b.dm_gnt !== 1'b1) begin
      fails++;
      $display("FAIL midreset_grant: got %0b expected 1", b.dm_gnt);
    end
    advance();
    reset = 1;
    b.dm_we = 1; b.dm_wdata = 32'hFFFFFFFF;
    settle();
    checks++;
    if (b.dm_rvalid !== 1'b0 || b.ram_en !== 1'b0 || b.ram_we !== 1'b0) begin
      fails++;
      $display("FAIL midreset_n1: got rvalid=%0b en=%0b we=%0b expected 0/0/0", b.dm_rvalid, b.ram_en, b.ram_we);
    end
    advance();
    reset = 0; idle();
    settle();
    checks++;
    if ({b.if_rvalid, b.dm_rvalid, b.ex_rvalid, b.misalign} !== 4'b0000) begin
      fails++;
      $display("FAIL midreset_n2: got %b expected 0000", {b.if_rvalid, b.dm_rvalid, b.ex_rvalid, b.misalign});
    end
    b.ex_req = 1; b.ex_addr = 32'h20;
    advance(); idle();
    settle();
    checks++;
    if (b.ex_rvalid !== 1'b1 || b.rdata !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL midreset_write_dropped: got rvalid=%0b rdata=%0h expected 1/cafef00d", b.ex_rvalid, b.rdata);
    end
    advance();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi, word, off;
    word = 32'($urandom_range(0, 63));
    hi   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
    off  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
    return (hi << (ADDR_W + 2)) | (word << 2) | off;
  endfunction

  task automatic test_random();
    bit hold_if = 0;
    bit hold_dm = 0;
    bit hold_ex = 0;
    int w;
    logic [31:0] a;
    bit exp_stall, exp_we;
    logic [2:0] exp_rv;
    idle();
    for (int n = 0; n < 500; n++) begin
      if (!hold_if) begin
        b.if_req = ($urandom_range(0, 99) < 60); b.if_addr = rand_addr();
      end
      if (!hold_dm) begin
        b.dm_req = ($urandom_range(0, 99) < 50); b.dm_we = ($urandom_range(0, 2) == 0);
        b.dm_addr = rand_addr(); b.dm_wdata = $urandom;
      end
      if (!hold_ex) begin
        b.ex_req = ($urandom_range(0, 99) < 40); b.ex_we = ($urandom_range(0, 2) == 0);
        b.ex_addr = rand_addr(); b.ex_wdata = $urandom;
      end
      settle();
      w         = predict();
      a         = req_addr(w);
      exp_we    = req_we(w) && (a % 4 == 0);
      exp_stall = (b.if_req && w != S_IF) || (b.dm_req && w != S_DM);
      exp_rv    = {m_pend == S_IF, m_pend == S_DM, m_pend == S_EX};
      checks++;
      if ({b.if_gnt, b.dm_gnt, b.ex_gnt} !== {w == S_IF, w == S_DM, w == S_EX}) begin
        fails++;
        $display("FAIL rand_gnt@%0d: got %b expected %b", n, {b.if_gnt, b.dm_gnt, b.ex_gnt}, {w == S_IF, w == S_DM, w == S_EX});
      end
      checks++;
      if (b.stall !== exp_stall) begin
        fails++;
        $display("FAIL rand_stall@%0d: got %0b expected %0b", n, b.stall, exp_stall);
      end
      checks++;
      if (b.ram_en !== (w != S_NONE) || b.ram_we !== exp_we) begin
        fails++;
        $display("FAIL rand_strobe@%0d: got en=%0b we=%0b expected %0b/%0b", n, b.ram_en, b.ram_we, w != S_NONE, exp_we);
      end
      if (w != S_NONE) begin
        checks++;
        if (b.ram_addr !== ADDR_W'(word_of(a))) begin
          fails++;
          $display("FAIL rand_ram_addr@%0d: got %0h expected %0h", n, b.ram_addr, word_of(a));
        end
      end
      if (exp_we) begin
        checks++;
        if (b.ram_wdata !== req_wdata(w)) begin
          fails++;
          $display("FAIL rand_wdata@%0d: got %0h expected %0h", n, b.ram_wdata, req_wdata(w));
        end
      end
      checks++;
      if ({b.if_rvalid, b.dm_rvalid, b.ex_rvalid} !== exp_rv) begin
        fails++;
        $display("FAIL rand_rvalid@%0d: got %b expected %b", n, {b.if_rvalid, b.dm_rvalid, b.ex_rvalid}, exp_rv);
      end
      if (m_pend != S_NONE) begin
        checks++;
        if (b.rdata !== m_pend_data) begin
          fails++;
          $display("FAIL rand_rdata@%0d: got %0h expected %0h", n, b.rdata, m_pend_data);
        end
      end
      checks++;
      if (b.misalign !== m_mis) begin
        fails++;
        $display("FAIL rand_misalign@%0d: got %0b expected %0b", n, b.misalign, m_mis);
      end
      hold_if = b.if_req && w != S_IF;
      hold_dm = b.dm_req && w != S_DM;
      hold_ex = b.ex_req && w != S_EX;
      advance();
    end
    idle();
    advance();
  endtask

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) ref_mem[i] = '0;
    m_starve = 0; m_rr_ex = 0; m_pend = S_NONE; m_pend_data = '0; m_mis = 0;
    idle();
    advance();
    advance();
    test_reset();
    test_single_if();
    test_dm_if_contention();
    test_round_robin();
    test_starvation();
    test_misaligned_write();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
